// File: rtl/dequant_4x4.sv
// Inverse quantiser for one 4x4 block: collects 16 zig-zag levels, scales each by the
// flat-matrix rule for the block QP, and presents the raster-ordered block with valid/ready.
module dequant_4x4 #(
  parameter int LEVEL_W    = 12,
  parameter int BIT_LENGTH = 15
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic signed [LEVEL_W-1:0]        in_level,
  input  logic [5:0]                       qp,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [15:0][BIT_LENGTH:0]        coeffs
);

  localparam int PW = LEVEL_W + 5;
  localparam int SW = LEVEL_W + 13;
  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-BIT_LENGTH){1'b0}}, {BIT_LENGTH{1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW-BIT_LENGTH){1'b1}}, {BIT_LENGTH{1'b0}}};

  typedef enum logic {COLLECT, HOLD} state_e;

  state_e                     state_q;
  logic [3:0]                 idx_q;
  logic [5:0]                 qp_q;
  logic                       out_valid_q;
  logic [15:0][BIT_LENGTH:0]  coeffs_q;

  logic [5:0]                 qp_live_d, qp_eff_d, qp_div_d, qp_mod_d;
  logic [3:0]                 pos_d;
  logic [1:0]                 cls_d;
  logic [4:0]                 scale_d;
  logic signed [PW-1:0]       prod_d;
  logic signed [SW-1:0]       shifted_d;
  logic [BIT_LENGTH:0]        deq_d;

  function automatic logic [3:0] zz_pos(input logic [3:0] idx);
    case (idx)
      4'd0:  zz_pos = 4'd0;
      4'd1:  zz_pos = 4'd1;
      4'd2:  zz_pos = 4'd4;
      4'd3:  zz_pos = 4'd8;
      4'd4:  zz_pos = 4'd5;
      4'd5:  zz_pos = 4'd2;
      4'd6:  zz_pos = 4'd3;
      4'd7:  zz_pos = 4'd6;
      4'd8:  zz_pos = 4'd9;
      4'd9:  zz_pos = 4'd12;
      4'd10: zz_pos = 4'd13;
      4'd11: zz_pos = 4'd10;
      4'd12: zz_pos = 4'd7;
      4'd13: zz_pos = 4'd11;
      4'd14: zz_pos = 4'd14;
      default: zz_pos = 4'd15;
    endcase
  endfunction

  function automatic logic [4:0] vscale(input logic [5:0] m, input logic [1:0] c);
    logic [14:0] row;
    case (m)
      6'd0:    row = {5'd10, 5'd16, 5'd13};
      6'd1:    row = {5'd11, 5'd18, 5'd14};
      6'd2:    row = {5'd13, 5'd20, 5'd16};
      6'd3:    row = {5'd14, 5'd23, 5'd18};
      6'd4:    row = {5'd16, 5'd25, 5'd20};
      default: row = {5'd18, 5'd29, 5'd23};
    endcase
    case (c)
      2'd0:    vscale = row[14:10];
      2'd1:    vscale = row[9:5];
      default: vscale = row[4:0];
    endcase
  endfunction

  // The first level of a block uses the live qp; the rest use the value latched with it.
  always_comb begin
    qp_live_d = (qp > 6'd51) ? 6'd51 : qp;
    qp_eff_d  = (idx_q == 4'd0) ? qp_live_d : qp_q;
    qp_div_d  = qp_eff_d / 6'd6;
    qp_mod_d  = qp_eff_d % 6'd6;
    pos_d     = zz_pos(idx_q);
    // pos[2] is the row LSB, pos[0] the column LSB.
    if (!pos_d[2] && !pos_d[0])     cls_d = 2'd0;
    else if (pos_d[2] && pos_d[0])  cls_d = 2'd1;
    else                            cls_d = 2'd2;
    scale_d   = vscale(qp_mod_d, cls_d);
    prod_d    = PW'(in_level) * PW'($signed({1'b0, scale_d}));
    shifted_d = SW'(prod_d) <<< qp_div_d[3:0];
    if (shifted_d > SAT_MAX)       deq_d = SAT_MAX[BIT_LENGTH:0];
    else if (shifted_d < SAT_MIN)  deq_d = SAT_MIN[BIT_LENGTH:0];
    else                           deq_d = shifted_d[BIT_LENGTH:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= COLLECT;
      idx_q       <= 4'd0;
      qp_q        <= 6'd0;
      out_valid_q <= 1'b0;
      coeffs_q    <= '0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (in_valid) begin
            coeffs_q[pos_d] <= deq_d;
            idx_q           <= idx_q + 4'd1;
            if (idx_q == 4'd0) qp_q <= qp_live_d;
            if (idx_q == 4'd15) begin
              state_q     <= HOLD;
              out_valid_q <= 1'b1;
            end
          end
        end
        default: begin
          if (out_ready) begin
            state_q     <= COLLECT;
            out_valid_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign in_ready  = reset && (state_q == COLLECT);
  assign out_valid = out_valid_q;
  assign coeffs    = coeffs_q;

endmodule

// File: tb/tb_dequant_4x4.sv
// Directed plus randomized bench for dequant_4x4, checked against an arithmetic
// reference model of the dequantisation rule.
module tb_dequant_4x4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic signed [11:0] in_level = '0;
  logic [5:0]        qp = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [15:0][15:0] coeffs;

  int vectors = 0;
  int miscompares = 0;

  int vtab [6][3] = '{'{10,16,13}, '{11,18,14}, '{13,20,16}, '{14,23,18}, '{16,25,20}, '{18,29,23}};
  int zz_tab [16] = '{0,1,4,8,5,2,3,6,9,12,13,10,7,11,14,15};
  int lv [16];
  logic [15:0] exp_c [16];

  dequant_4x4 #(.LEVEL_W(12), .BIT_LENGTH(15)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_level(in_level), .qp(qp), .out_valid(out_valid), .out_ready(out_ready),
    .coeffs(coeffs)
  );

  always #5 clk = ~clk;

  function automatic int ref_deq(int level, int qpv, int pos);
    int q, r, c, cls;
    longint d;
    q = (qpv > 51) ? 51 : qpv;
    r = pos / 4;
    c = pos % 4;
    if (r % 2 == 0 && c % 2 == 0)      cls = 0;
    else if (r % 2 == 1 && c % 2 == 1) cls = 1;
    else                               cls = 2;
    d = longint'(level) * longint'(vtab[q % 6][cls]) * (longint'(1) << (q / 6));
    if (d > 32767) d = 32767;
    if (d < -32768) d = -32768;
    return int'(d);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic build_exp(input int q0);
    for (int k = 0; k < 16; k++) exp_c[zz_tab[k]] = 16'(ref_deq(lv[k], q0, zz_tab[k]));
  endtask

  task automatic send_levels(input int q0, input int n, input bit gaps);
    logic [11:0] junk;
    for (int k = 0; k < n; k++) begin
      if (gaps) begin
        repeat ($urandom % 3) begin
          @(negedge clk);
          in_valid = 1'b0;
          junk = 12'($urandom);
          in_level = junk;
        end
      end
      @(negedge clk);
      chk($sformatf("in_ready_k%0d", k), 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_level = 12'(lv[k]);
      qp = (k == 0) ? 6'(q0) : 6'($urandom % 64);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic check_block(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    for (int i = 0; i < 16; i++) chk($sformatf("%s_c%0d", tag, i), 32'(coeffs[i]), 32'(exp_c[i]));
  endtask

  task automatic release_block(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_rel_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_rel_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic rand_levels();
    logic [11:0] t;
    for (int k = 0; k < 16; k++) begin
      t = 12'($urandom);
      lv[k] = ($urandom % 2) ? int'($signed(t)) : int'($urandom_range(0, 40)) - 20;
    end
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 16; i++) chk($sformatf("rst_c%0d", i), 32'(coeffs[i]), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // T1: all ones at qp 0
    for (int k = 0; k < 16; k++) lv[k] = 1;
    send_levels(0, 16, 1'b0);
    build_exp(0);
    check_block("t1");
    chk("t1_c0", 32'(coeffs[0]), 32'd10);
    chk("t1_c5", 32'(coeffs[5]), 32'd16);
    chk("t1_c1", 32'(coeffs[1]), 32'd13);
    chk("t1_c15", 32'(coeffs[15]), 32'd16);
    chk("t1_c4", 32'(coeffs[4]), 32'd13);
    release_block("t1");

    // T2: ramp
    for (int k = 0; k < 16; k++) lv[k] = k + 1;
    send_levels(0, 16, 1'b0);
    build_exp(0);
    check_block("t2");
    chk("t2_c4", 32'(coeffs[4]), 32'd39);
    chk("t2_c12", 32'(coeffs[12]), 32'd130);
    chk("t2_c15", 32'(coeffs[15]), 32'd256);
    chk("t2_c10", 32'(coeffs[10]), 32'd120);
    release_block("t2");

    // T3: negative DC at qp 30
    for (int k = 0; k < 16; k++) lv[k] = 0;
    lv[0] = -7;
    send_levels(30, 16, 1'b0);
    build_exp(30);
    check_block("t3");
    chk("t3_c0", 32'(coeffs[0]), 32'h0000_F740);
    release_block("t3");

    // T4: saturation at qp 51, then qp 60 clamps to 51
    rand_levels();
    lv[0] = 2047;
    send_levels(51, 16, 1'b0);
    build_exp(51);
    check_block("t4a");
    chk("t4a_c0", 32'(coeffs[0]), 32'h0000_7FFF);
    release_block("t4a");
    lv[0] = -2048;
    send_levels(51, 16, 1'b0);
    build_exp(51);
    check_block("t4b");
    chk("t4b_c0", 32'(coeffs[0]), 32'h0000_8000);
    release_block("t4b");
    send_levels(60, 16, 1'b1);
    build_exp(51);
    check_block("t4c");
    release_block("t4c");

    // T5: downstream back-pressure
    rand_levels();
    send_levels(int'($urandom % 52), 16, 1'b1);
    build_exp(int'(qp_first_snapshot()));
    repeat (5) begin
      @(posedge clk);
      #1;
      check_block("t5");
    end
    release_block("t5");

    // T6: reset mid-block, then a fresh block
    rand_levels();
    send_levels(17, 7, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 16; i++) chk($sformatf("t6_rst_c%0d", i), 32'(coeffs[i]), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 16; k++) lv[k] = 1;
    send_levels(6, 16, 1'b0);
    build_exp(6);
    check_block("t6");
    chk("t6_c0", 32'(coeffs[0]), 32'(16'(ref_deq(1, 6, 0))));

    // Reset while holding drops the block immediately
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t6_hold_rst_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Randomized blocks with input gaps and random release delays
    for (int b = 0; b < 30; b++) begin
      int q0;
      q0 = int'($urandom % 64);
      rand_levels();
      send_levels(q0, 16, 1'b1);
      build_exp(q0);
      check_block($sformatf("rnd%0d", b));
      repeat ($urandom % 3) @(posedge clk);
      release_block($sformatf("rnd%0d", b));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // qp value driven with scan index 0 of the most recent block, clamped the way the model expects.
  logic [5:0] qp_first_q = '0;
  always @(posedge clk) if (in_valid && in_ready && dut_idx_zero()) qp_first_q <= qp;

  int beat_cnt = 0;
  always @(posedge clk or negedge reset) begin
    if (!reset) beat_cnt <= 0;
    else if (in_valid && in_ready) beat_cnt <= (beat_cnt == 15) ? 0 : beat_cnt + 1;
  end

  function automatic bit dut_idx_zero();
    return beat_cnt == 0;
  endfunction

  function automatic logic [5:0] qp_first_snapshot();
    return qp_first_q;
  endfunction

endmodule
